pixel_scheduler: RTL and testbench

Frame-level controller that feeds the `check_objects` intersection pipeline. It walks every pixel of a frame in raster order and issues one (hcount, vcount, select_objs) request per pixel to the ray-generation / `check_objects` input stream. It meters requests with an in-flight credit counter, because the pipeline's result side has no backpressure and must never hold more than `MAX_INFLIGHT` pixels. It counts returning results and signals frame completion.

---
 rtl/raytrace_pkg.sv | 23 ++
 rtl/pixel_scheduler_if.sv | 27 ++
 rtl/pixel_scheduler_credit_counter.sv | 39 +++
 rtl/pixel_scheduler.sv | 115 +++++++++++
 tb/tb_pixel_scheduler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/raytrace_pkg.sv
// Shared types for the ray-trace frame path: counter widths, object-select codes, scheduler FSM states.
package raytrace_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    typedef logic [1:0] sel_objs_t;
    localparam sel_objs_t SEL_CYL  = 2'b01;
    localparam sel_objs_t SEL_SPH  = 2'b10;
    localparam sel_objs_t SEL_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    function automatic int total_pixels(input int h_res, input int v_res);
        return h_res * v_res;
    endfunction

endpackage

// File: rtl/pixel_scheduler_if.sv
// Ray-request stream toward ray generation / check_objects: one pixel coordinate plus object select per beat.
interface pixel_scheduler_if;
    import raytrace_pkg::*;

    logic                ray_axis_tvalid;
    logic                ray_axis_tready;
    logic [HCOUNT_W-1:0] hcount_axis_tdata;
    logic [VCOUNT_W-1:0] vcount_axis_tdata;
    sel_objs_t           select_objs;

    modport master (
        output ray_axis_tvalid,
        output hcount_axis_tdata,
        output vcount_axis_tdata,
        output select_objs,
        input  ray_axis_tready
    );

    modport slave (
        input  ray_axis_tvalid,
        input  hcount_axis_tdata,
        input  vcount_axis_tdata,
        input  select_objs,
        output ray_axis_tready
    );

endinterface

// File: rtl/pixel_scheduler_credit_counter.sv
// In-flight pixel credit counter: +1 per issued request, -1 per returned result, floor at 0.
// A result arriving with no credit outstanding is dropped and latches a sticky error.
module credit_counter #(
    parameter int MAX_INFLIGHT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [7:0] o_count,
    output logic       o_full,
    output logic       o_dec_ok,
    output logic       o_err
);

    logic [7:0] r_count;
    logic       r_err;
    logic       w_dec_ok;

    assign w_dec_ok = i_dec && (r_count != 8'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            if (i_dec && !w_dec_ok) begin
                r_err <= 1'b1;
            end
            r_count <= r_count + 8'(i_inc) - 8'(w_dec_ok);
        end
    end

    assign o_count  = r_count;
    assign o_full   = (r_count >= 8'(MAX_INFLIGHT));
    assign o_dec_ok = w_dec_ok;
    assign o_err    = r_err;

endmodule

// File: rtl/pixel_scheduler.sv
// Walks a frame in raster order issuing one ray request per pixel, metered by in-flight credits,
// and pulses frame_done once every issued pixel's result has come back.
module pixel_scheduler
    import raytrace_pkg::*;
#(
    parameter int H_RES        = 320,
    parameter int V_RES        = 180,
    parameter int MAX_INFLIGHT = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      start,
    input  sel_objs_t                 select_objs_cfg,
    pixel_scheduler_if.master         ray,
    input  logic                      result_valid,
    output logic                      busy,
    output logic                      frame_done,
    output logic [7:0]                inflight,
    output logic                      overflow_err
);

    localparam int TOTAL = total_pixels(H_RES, V_RES);
    localparam int RES_W = $clog2(TOTAL + 1);
    localparam logic [HCOUNT_W-1:0] H_LAST  = HCOUNT_W'(H_RES - 1);
    localparam logic [VCOUNT_W-1:0] V_LAST  = VCOUNT_W'(V_RES - 1);
    localparam logic [RES_W-1:0]    TOTAL_R = RES_W'(TOTAL);

    sched_state_t        r_state;
    logic [HCOUNT_W-1:0] r_hcount;
    logic [VCOUNT_W-1:0] r_vcount;
    sel_objs_t           r_sel;
    logic [RES_W-1:0]    r_results;

    logic w_full;
    logic w_valid;
    logic w_hs;
    logic w_res_ok;

    // Valid depends only on registers, so it can fall only after a handshake raises the credit count.
    assign w_valid = (r_state == ST_RUN) && !w_full;
    assign w_hs    = w_valid && ray.ray_axis_tready;

    credit_counter #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_credit (
        .clk      (aclk),
        .rst_n    (aresetn),
        .i_inc    (w_hs),
        .i_dec    (result_valid),
        .o_count  (inflight),
        .o_full   (w_full),
        .o_dec_ok (w_res_ok),
        .o_err    (overflow_err)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_hcount  <= '0;
            r_vcount  <= '0;
            r_sel     <= '0;
            r_results <= '0;
        end else begin
            if (w_res_ok) begin
                r_results <= r_results + RES_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sel     <= select_objs_cfg;
                        r_hcount  <= '0;
                        r_vcount  <= '0;
                        r_results <= '0;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_hs) begin
                        if (r_hcount == H_LAST) begin
                            // Last pixel holds its coordinates through DRAIN/DONE.
                            if (r_vcount == V_LAST) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_hcount <= '0;
                                r_vcount <= r_vcount + VCOUNT_W'(1);
                            end
                        end else begin
                            r_hcount <= r_hcount + HCOUNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_results == TOTAL_R) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ray.ray_axis_tvalid   = w_valid;
    assign ray.hcount_axis_tdata = r_hcount;
    assign ray.vcount_axis_tdata = r_vcount;
    assign ray.select_objs       = r_sel;

    assign busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign frame_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_pixel_scheduler.sv
// Bench for pixel_scheduler: randomized ready/latency traffic against a frame-level reference model.
module tb_pixel_scheduler;
    import raytrace_pkg::*;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int MAXF = 3;
    localparam int TOT  = H * V;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       start = 1'b0;
    logic       result_valid = 1'b0;
    sel_objs_t  cfg = '0;
    logic       busy;
    logic       frame_done;
    logic [7:0] inflight;
    logic       overflow_err;

    pixel_scheduler_if rif();

    pixel_scheduler #(
        .H_RES        (H),
        .V_RES        (V),
        .MAX_INFLIGHT (MAXF)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .start           (start),
        .select_objs_cfg (cfg),
        .ray             (rif),
        .result_valid    (result_valid),
        .busy            (busy),
        .frame_done      (frame_done),
        .inflight        (inflight),
        .overflow_err    (overflow_err)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: frame progress expressed as pixel index and credit/result tallies.
    int m_st, m_pix, m_inflight, m_results, m_err, m_sel;
    int m_frame_hs, m_done_exp, obs_done, sim_seen;
    int ret_q[$];
    int last_ret = 0;
    int lat_min = 5, lat_max = 5;
    int ready_mode = 0;
    bit force_res = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic reset_model();
        m_st = M_IDLE; m_pix = 0; m_inflight = 0; m_results = 0; m_err = 0; m_sel = 0;
        m_frame_hs = 0;
        ret_q.delete();
    endtask

    task automatic cycle();
        bit hs, rok, exp_valid;
        int t, obs_idx;
        case (ready_mode)
            0:       rif.ray_axis_tready = 1'b1;
            1:       rif.ray_axis_tready = (cyc % 3 == 0);
            default: rif.ray_axis_tready = 1'($urandom_range(0, 1));
        endcase
        result_valid = 1'b0;
        if (force_res) begin
            result_valid = 1'b1;
        end else if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
            result_valid = 1'b1;
            void'(ret_q.pop_front());
        end

        exp_valid = (m_st == M_RUN) && (m_inflight < MAXF);
        chk("tvalid",     32'(rif.ray_axis_tvalid),   32'(exp_valid));
        chk("hcount",     32'(rif.hcount_axis_tdata), 32'(m_pix % H));
        chk("vcount",     32'(rif.vcount_axis_tdata), 32'(m_pix / H));
        chk("select",     32'(rif.select_objs),       32'(m_sel));
        chk("busy",       32'(busy),       32'(m_st == M_RUN || m_st == M_DRAIN));
        chk("frame_done", 32'(frame_done), 32'(m_st == M_DONE));
        chk("inflight",   32'(inflight),   32'(m_inflight));
        chk("overflow",   32'(overflow_err), 32'(m_err));
        if (frame_done === 1'b1) obs_done++;

        hs  = exp_valid && rif.ray_axis_tready;
        rok = result_valid && (m_inflight > 0);
        if (!aresetn) begin
            reset_model();
        end else begin
            if (result_valid && m_inflight == 0) m_err = 1;
            if (hs && rok && m_inflight == 2) sim_seen++;
            if (hs) begin
                obs_idx = int'(rif.hcount_axis_tdata) + H * int'(rif.vcount_axis_tdata);
                chk("raster", 32'(obs_idx), 32'(m_frame_hs));
                m_frame_hs++;
                t = cyc + $urandom_range(lat_min, lat_max);
                if (t <= last_ret) t = last_ret + 1;
                last_ret = t;
                ret_q.push_back(t);
            end
            case (m_st)
                M_IDLE: if (start) begin
                    m_sel = int'(cfg); m_pix = 0; m_results = 0; m_frame_hs = 0; m_st = M_RUN;
                end
                M_RUN: if (hs) begin
                    if (m_pix == TOT - 1) m_st = M_DRAIN;
                    else m_pix++;
                end
                M_DRAIN: if (m_results == TOT) begin
                    m_st = M_DONE;
                    m_done_exp++;
                end
                default: m_st = M_IDLE;
            endcase
            if (rok) m_results++;
            m_inflight = m_inflight + int'(hs) - int'(rok);
        end
        @(posedge aclk);
        cyc++;
        @(negedge aclk);
    endtask

    task automatic run_frame(input sel_objs_t sel, input bit noisy_start);
        int n;
        cfg = sel;
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (m_st != M_IDLE && n < 400) begin
            if (noisy_start) begin
                start = (m_st == M_DONE) ? 1'b1 : 1'($urandom_range(0, 1));
                cfg   = sel_objs_t'($urandom_range(0, 3));
            end
            cycle();
            n++;
        end
        start = 1'b0;
        if (n >= 400) chk("frame_timeout", 32'd1, 32'd0);
        chk("done_pulses", 32'(obs_done), 32'(m_done_exp));
        chk("frame_hs", 32'(m_frame_hs), 32'(TOT));
        cycle();
    endtask

    initial begin
        rif.ray_axis_tready = 1'b1;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        reset_model();
        m_done_exp = 0; obs_done = 0; sim_seen = 0;
        aresetn = 1'b1;
        cycle();
        cycle();

        // Nominal frame: ready=1, fixed 5-cycle return latency.
        ready_mode = 0; lat_min = 5; lat_max = 5;
        run_frame(SEL_BOTH, 1'b0);

        // Backpressure with ready 1,0,0 repeating.
        ready_mode = 1; lat_min = 1; lat_max = 6;
        run_frame(SEL_CYL, 1'b0);

        // Short latency lets issue and return collide at various credit levels.
        ready_mode = 0; lat_min = 2; lat_max = 2;
        run_frame(SEL_SPH, 1'b0);

        // Spurious result in IDLE, then a normal frame with the error still set.
        force_res = 1'b1;
        cycle();
        force_res = 1'b0;
        cycle();
        chk("overflow_sticky", 32'(overflow_err), 32'd1);
        ready_mode = 2; lat_min = 1; lat_max = 4;
        run_frame(SEL_BOTH, 1'b0);

        // Reset after three handshakes mid-RUN.
        ready_mode = 0; lat_min = 6; lat_max = 6;
        cfg = SEL_CYL;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 20 && m_frame_hs < 3; i++) cycle();
        aresetn = 1'b0;
        cycle();
        aresetn = 1'b1;
        cycle();
        chk("rst_inflight", 32'(inflight), 32'd0);
        run_frame(SEL_SPH, 1'b0);

        // Starts pulsed during RUN/DRAIN/DONE with changing cfg must be ignored.
        ready_mode = 2; lat_min = 1; lat_max = 5;
        run_frame(SEL_CYL, 1'b1);

        for (int f = 0; f < 4; f++) begin
            ready_mode = 2;
            lat_min = $urandom_range(1, 3);
            lat_max = lat_min + $urandom_range(0, 4);
            run_frame(sel_objs_t'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end

        chk("simultaneous_seen", 32'(sim_seen > 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
